// File: rtl/output_buffer_pkg.sv
// Shared types and defaults for the output buffer slice.
package output_buffer_pkg;

   localparam int unsigned DEF_DATA_W = 16;
   localparam int unsigned DEF_DEPTH  = 32;

   typedef enum logic {
      MODE_INDEXED = 1'b0,
      MODE_STREAM  = 1'b1
   } mode_e;

endpackage

// File: rtl/output_buffer_if.sv
// Control, data and status bundle between the output buffer and its surroundings.
interface output_buffer_if import output_buffer_pkg::*; #(
   parameter int unsigned DATA_W = DEF_DATA_W,
   parameter int unsigned DEPTH  = DEF_DEPTH
);
   localparam int unsigned ADDR_W = $clog2(DEPTH);

   logic              mode;
   logic              clear;
   logic              wr_en;
   logic [DATA_W-1:0] wr_data;
   logic [ADDR_W-1:0] wr_index;
   logic [ADDR_W-1:0] rd_index;
   logic [DATA_W-1:0] rd_data;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_data;
   logic [ADDR_W:0]   count;
   logic              full;
   logic              empty;
   logic              overflow;

   modport master (
      output mode, clear, wr_en, wr_data, wr_index, rd_index, out_ready,
      input  rd_data, out_valid, out_data, count, full, empty, overflow
   );

   modport slave (
      input  mode, clear, wr_en, wr_data, wr_index, rd_index, out_ready,
      output rd_data, out_valid, out_data, count, full, empty, overflow
   );

endinterface

// File: rtl/output_buffer_mem.sv
// Storage array with per-entry valid bits, one write port and two combinational reads.
module output_buffer_mem #(
   parameter int unsigned DATA_W = 16,
   parameter int unsigned DEPTH  = 32,
   parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              vld_clr,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [ADDR_W-1:0] idx_addr,
   output logic [DATA_W-1:0] idx_data,
   input  logic [ADDR_W-1:0] head_addr,
   output logic [DATA_W-1:0] head_data
);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [DEPTH-1:0]  valid;

   // Array contents are deliberately unreset; the valid bits mask stale data.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid <= '0;
      end else if (vld_clr) begin
         valid <= '0;
      end else if (we) begin
         valid[waddr] <= 1'b1;
      end
   end

   assign idx_data  = valid[idx_addr] ? mem[idx_addr] : '0;
   assign head_data = mem[head_addr];

endmodule

// File: rtl/output_buffer.sv
// Output storage: indexed register file or in-order stream FIFO, selected at run time.
module output_buffer import output_buffer_pkg::*; #(
   parameter int unsigned DATA_W = DEF_DATA_W,
   parameter int unsigned DEPTH  = DEF_DEPTH
) (
   input  logic             clk,
   input  logic             rst_n,
   output_buffer_if.slave   bus
);

   localparam int unsigned     ADDR_W   = $clog2(DEPTH);
   localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

   mode_e             mode_q, mode_d, mode_in;
   logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [ADDR_W:0]   count_q, count_d;
   logic              ovf_q, ovf_d;

   logic              flush, stream, push_req, push_ok, pop;
   logic              full, empty, out_valid;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_waddr;
   logic [DATA_W-1:0] idx_data, head_data;

   assign mode_in   = mode_e'(bus.mode);
   assign stream    = (mode_q == MODE_STREAM);
   assign full      = (count_q == FULL_CNT);
   assign empty     = (count_q == '0);
   assign out_valid = stream && !empty;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mode_q   <= MODE_INDEXED;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         ovf_q    <= 1'b0;
      end else begin
         mode_q   <= mode_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         ovf_q    <= ovf_d;
      end
   end

   always_comb begin
      mode_d    = mode_in;
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      count_d   = count_q;
      ovf_d     = ovf_q;
      // A mode change behaves exactly like clear, so both fold into one flush.
      flush     = bus.clear || (mode_in != mode_q);
      push_req  = stream && bus.wr_en && !flush;
      pop       = out_valid && bus.out_ready && !flush;
      push_ok   = push_req && (!full || pop);
      mem_we    = stream ? push_ok : (bus.wr_en && !flush);
      mem_waddr = stream ? wr_ptr_q : bus.wr_index;

      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
         ovf_d    = 1'b0;
      end else begin
         if (push_ok) begin
            wr_ptr_d = wr_ptr_q + ADDR_W'(1);
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + ADDR_W'(1);
         end
         case ({push_ok, pop})
            2'b10:   count_d = count_q + (ADDR_W+1)'(1);
            2'b01:   count_d = count_q - (ADDR_W+1)'(1);
            default: count_d = count_q;
         endcase
         if (push_req && !push_ok) begin
            ovf_d = 1'b1;
         end
      end
   end

   output_buffer_mem #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) u_mem (
      .clk       (clk),
      .rst_n     (rst_n),
      .vld_clr   (flush),
      .we        (mem_we),
      .waddr     (mem_waddr),
      .wdata     (bus.wr_data),
      .idx_addr  (bus.rd_index),
      .idx_data  (idx_data),
      .head_addr (rd_ptr_q),
      .head_data (head_data)
   );

   assign bus.rd_data   = stream ? '0 : idx_data;
   assign bus.out_valid = out_valid;
   assign bus.out_data  = out_valid ? head_data : '0;
   assign bus.count     = count_q;
   assign bus.full      = full;
   assign bus.empty     = empty;
   assign bus.overflow  = ovf_q;

endmodule

// File: tb/tb_output_buffer.sv
// Directed bench for output_buffer with a stream scoreboard and immediate assertions.
module tb_output_buffer;
   import output_buffer_pkg::*;

   localparam int unsigned DATA_W = 16;
   localparam int unsigned DEPTH  = 32;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   output_buffer_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

   output_buffer #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int unsigned       n_checks = 0;
   int unsigned       n_errors = 0;
   logic [DATA_W-1:0] sb [$];
   logic              mode_m = 1'b0;
   logic              ovf_m  = 1'b0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One clock: check stream head, update the model, advance, check status.
   task automatic tick();
      int   pre;
      logic pop;
      check("out_valid", 32'(bus.out_valid), 32'(mode_m && (sb.size() > 0)));
      if (bus.clear || (bus.mode != mode_m)) begin
         sb.delete();
         ovf_m  = 1'b0;
         mode_m = bus.mode;
      end else if (mode_m) begin
         pre = sb.size();
         pop = (pre > 0) && bus.out_ready;
         if (pop) begin
            check("out_data", 32'(bus.out_data), 32'(sb.pop_front()));
         end else if (pre == 0) begin
            check("out_data_idle", 32'(bus.out_data), 32'h0);
         end
         if (bus.wr_en) begin
            if ((pre < int'(DEPTH)) || pop) sb.push_back(bus.wr_data);
            else ovf_m = 1'b1;
         end
      end
      @(posedge clk);
      #1;
      check("count",    32'(bus.count),    32'(sb.size()));
      check("full",     32'(bus.full),     32'(sb.size() == DEPTH));
      check("empty",    32'(bus.empty),    32'(sb.size() == 0));
      check("overflow", 32'(bus.overflow), 32'(ovf_m));
   endtask

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

   initial begin
      bus.mode      = 1'b0;
      bus.clear     = 1'b0;
      bus.wr_en     = 1'b0;
      bus.wr_data   = '0;
      bus.wr_index  = '0;
      bus.rd_index  = '0;
      bus.out_ready = 1'b0;

      #1;
      check("rst_out_valid", 32'(bus.out_valid), 32'h0);
      check("rst_empty",     32'(bus.empty),     32'h1);
      check("rst_full",      32'(bus.full),      32'h0);
      check("rst_count",     32'(bus.count),     32'h0);
      check("rst_rd_data",   32'(bus.rd_data),   32'h0);
      check("rst_out_data",  32'(bus.out_data),  32'h0);
      #11 rst_n = 1'b1;

      // Indexed mode
      bus.wr_en = 1'b1; bus.wr_index = 5; bus.wr_data = 16'h1234;
      tick();
      bus.wr_en = 1'b0; bus.rd_index = 5;
      #1 check("idx_rd5", 32'(bus.rd_data), 32'h1234);
      bus.rd_index = 6;
      #1 check("idx_rd6", 32'(bus.rd_data), 32'h0);
      bus.wr_en = 1'b1; bus.wr_index = 5; bus.wr_data = 16'hBEEF; bus.rd_index = 5;
      #1 check("idx_same_cycle_old", 32'(bus.rd_data), 32'h1234);
      tick();
      bus.wr_en = 1'b0;
      #1 check("idx_new", 32'(bus.rd_data), 32'hBEEF);

      // Stream: fill, overflow, drain
      bus.mode = 1'b1;
      tick();
      check("stream_rd_data", 32'(bus.rd_data), 32'h0);
      for (int i = 1; i <= 32; i++) begin
         bus.wr_en = 1'b1; bus.wr_data = DATA_W'(i);
         tick();
      end
      check("fill_full",  32'(bus.full),  32'h1);
      check("fill_count", 32'(bus.count), 32'd32);
      bus.wr_data = 16'hDEAD;
      tick();
      check("ovf_set", 32'(bus.overflow), 32'h1);
      bus.wr_en = 1'b0; bus.out_ready = 1'b1;
      repeat (32) tick();
      check("drain_empty", 32'(bus.empty), 32'h1);

      // Full with simultaneous push and pop
      bus.out_ready = 1'b0; bus.clear = 1'b1;
      tick();
      bus.clear = 1'b0;
      for (int i = 1; i <= 32; i++) begin
         bus.wr_en = 1'b1; bus.wr_data = DATA_W'(16'h0100 + i);
         tick();
      end
      bus.wr_data = 16'h00AA; bus.out_ready = 1'b1;
      tick();
      check("pp_count",    32'(bus.count),    32'd32);
      check("pp_overflow", 32'(bus.overflow), 32'h0);
      bus.wr_en = 1'b0;
      repeat (31) tick();
      check("pp_last", 32'(bus.out_data), 32'h00AA);
      tick();

      // Wrap-around with occupancy held at 3
      bus.out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         bus.wr_en = 1'b1; bus.wr_data = DATA_W'(16'h0300 + i);
         tick();
      end
      bus.out_ready = 1'b1;
      for (int i = 0; i < 100; i++) begin
         bus.wr_data = DATA_W'(16'h0400 + i);
         tick();
      end
      check("wrap_count", 32'(bus.count), 32'd3);
      bus.wr_en = 1'b0;
      repeat (3) tick();

      // Clear beats a same-cycle write
      bus.out_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         bus.wr_en = 1'b1; bus.wr_data = DATA_W'(16'h0600 + i);
         tick();
      end
      bus.clear = 1'b1; bus.wr_data = 16'hCCCC;
      tick();
      bus.clear = 1'b0; bus.wr_en = 1'b0;
      check("clr_count",     32'(bus.count),     32'h0);
      check("clr_empty",     32'(bus.empty),     32'h1);
      check("clr_out_valid", 32'(bus.out_valid), 32'h0);
      check("clr_overflow",  32'(bus.overflow),  32'h0);

      // Mode toggle with entries queued; write in the toggle cycle is dropped
      for (int i = 0; i < 2; i++) begin
         bus.wr_en = 1'b1; bus.wr_data = DATA_W'(16'h0700 + i);
         tick();
      end
      bus.mode = 1'b0; bus.wr_index = 7; bus.wr_data = 16'h7777;
      tick();
      bus.wr_en = 1'b0;
      check("toggle_count", 32'(bus.count), 32'h0);
      bus.rd_index = 5;
      #1 check("toggle_rd5", 32'(bus.rd_data), 32'h0);
      bus.rd_index = 7;
      #1 check("toggle_rd7", 32'(bus.rd_data), 32'h0);

      // Asynchronous reset mid-stream
      bus.mode = 1'b1;
      tick();
      for (int i = 0; i < 7; i++) begin
         bus.wr_en = 1'b1; bus.wr_data = DATA_W'(16'h0800 + i);
         tick();
      end
      bus.wr_en = 1'b0;
      check("pre_rst_count", 32'(bus.count), 32'd7);
      #3 rst_n = 1'b0;
      #1;
      check("arst_out_valid", 32'(bus.out_valid), 32'h0);
      check("arst_empty",     32'(bus.empty),     32'h1);
      check("arst_full",      32'(bus.full),      32'h0);
      check("arst_count",     32'(bus.count),     32'h0);
      check("arst_overflow",  32'(bus.overflow),  32'h0);
      check("arst_out_data",  32'(bus.out_data),  32'h0);
      check("arst_rd_data",   32'(bus.rd_data),   32'h0);
      sb.delete();
      ovf_m  = 1'b0;
      mode_m = 1'b0;
      #2 rst_n = 1'b1;
      tick();
      bus.wr_en = 1'b1; bus.wr_data = 16'h5A5A;
      tick();
      bus.wr_en = 1'b0;
      check("post_rst_valid", 32'(bus.out_valid), 32'h1);
      check("post_rst_data",  32'(bus.out_data),  32'h5A5A);
      bus.out_ready = 1'b1;
      tick();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
